// File: rtl/led_arb_pkg.sv
// rtl/led_arb_pkg.sv - shared types and constants for the LED PIO arbiter
// Purpose: arbiter FSM state type and Avalon PIO constants.
// Ports: none (package).
package led_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [1:0] LED_PIO_DATA_ADDR = 2'd0;
   localparam int         AVALON_DATA_W     = 32;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker
// Purpose: choose the first active request after 'last', wrapping modulo NUM_REQ.
// Ports:
//   req          in   NUM_REQ   active requests
//   last         in   IDX_W     most recently granted index
//   grant_idx    out  IDX_W     chosen requester (equals last when none requested)
//   grant_valid  out  1         at least one request is active
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_valid
);

   // last < NUM_REQ and off <= NUM_REQ, so one conditional subtract wraps correctly.
   function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      return IDX_W'(sum);
   endfunction

   // Scan from the farthest candidate to the nearest so the nearest active one wins.
   always_comb begin
      grant_idx   = last;
      grant_valid = 1'b0;
      for (int off = NUM_REQ; off >= 1; off--) begin
         if (req[wrap_idx(last, off)]) begin
            grant_idx   = wrap_idx(last, off);
            grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/led_pio_arbiter.sv
// rtl/led_pio_arbiter.sv - round-robin sharing of the LED PIO between requesters
// Purpose: grant one requester at a time, write its value to the PIO data register in a
//   single Avalon write cycle, then hold off for HOLD_CYCLES so the pattern stays visible.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   req, req_data     level requests and per-requester data (slice i*DATA_W)
//   ack               one-cycle pulse in the write cycle for the granted requester
//   pio_*             Avalon-MM master side towards the PIO s1 slave
//   owner             last granted requester
//   busy              high while writing or holding
module led_pio_arbiter
   import led_arb_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = 8,
   parameter int HOLD_CYCLES = 16,
   localparam int IDX_W      = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        ack,
   output logic [1:0]                pio_address,
   output logic                      pio_chipselect,
   output logic                      pio_write_n,
   output logic [AVALON_DATA_W-1:0]  pio_writedata,
   output logic [IDX_W-1:0]          owner,
   output logic                      busy
);

   localparam int CNT_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);

   state_t                     state_q, state_d;
   logic [CNT_W-1:0]           hold_cnt_q, hold_cnt_d;
   logic [NUM_REQ-1:0]         ack_q, ack_d;
   logic                       cs_q, cs_d;
   logic                       write_n_q, write_n_d;
   logic [AVALON_DATA_W-1:0]   writedata_q, writedata_d;
   logic [IDX_W-1:0]           owner_q, owner_d;
   logic                       busy_q, busy_d;
   logic [IDX_W-1:0]           grant_idx;
   logic                       grant_valid;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req         (req),
      .last        (owner_q),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   // Output registers are loaded for the cycle they describe: the grant edge already
   // sets up the strobe and ack so both appear in the WRITE cycle itself.
   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      ack_d       = '0;
      cs_d        = 1'b0;
      write_n_d   = 1'b1;
      writedata_d = writedata_q;
      owner_d     = owner_q;
      busy_d      = busy_q;
      unique case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (grant_valid) begin
               state_d          = WRITE;
               owner_d          = grant_idx;
               ack_d[grant_idx] = 1'b1;
               cs_d             = 1'b1;
               write_n_d        = 1'b0;
               writedata_d      = AVALON_DATA_W'(req_data[grant_idx*DATA_W +: DATA_W]);
               busy_d           = 1'b1;
            end
         end
         WRITE: begin
            if (HOLD_CYCLES == 0) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else begin
               state_d    = HOLD;
               hold_cnt_d = CNT_W'(HOLD_CYCLES);
               busy_d     = 1'b1;
            end
         end
         HOLD: begin
            busy_d = 1'b1;
            if (hold_cnt_q <= CNT_W'(1)) begin
               state_d    = IDLE;
               hold_cnt_d = '0;
               busy_d     = 1'b0;
            end else begin
               hold_cnt_d = hold_cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         hold_cnt_q  <= '0;
         ack_q       <= '0;
         cs_q        <= 1'b0;
         write_n_q   <= 1'b1;
         writedata_q <= '0;
         owner_q     <= IDX_W'(NUM_REQ - 1);
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         ack_q       <= ack_d;
         cs_q        <= cs_d;
         write_n_q   <= write_n_d;
         writedata_q <= writedata_d;
         owner_q     <= owner_d;
         busy_q      <= busy_d;
      end
   end

   assign ack            = ack_q;
   assign pio_address    = LED_PIO_DATA_ADDR;
   assign pio_chipselect = cs_q;
   assign pio_write_n    = write_n_q;
   assign pio_writedata  = writedata_q;
   assign owner          = owner_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_led_pio_arbiter.sv
// tb/tb_led_pio_arbiter.sv - self-checking bench for led_pio_arbiter
module tb_led_pio_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;

   logic                  clk = 1'b0;
   logic [1:0]            rst_n;
   logic [1:0][N-1:0]     req;
   logic [1:0][N*DW-1:0]  req_data;
   logic [1:0][N-1:0]     ack;
   logic [1:0][1:0]       addr;
   logic [1:0]            cs, wn, busy;
   logic [1:0][31:0]      wd;
   logic [1:0][1:0]       own;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // reference model state, one slot per DUT instance
   logic [1:0][N-1:0]     e_ack;
   logic [1:0]            e_cs, e_wn, e_busy;
   logic [1:0][31:0]      e_wd;
   int                    e_own [2];
   int                    blocked [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   led_pio_arbiter #(.NUM_REQ(N), .DATA_W(DW), .HOLD_CYCLES(16)) dut (
      .clk(clk), .reset_n(rst_n[0]), .req(req[0]), .req_data(req_data[0]), .ack(ack[0]),
      .pio_address(addr[0]), .pio_chipselect(cs[0]), .pio_write_n(wn[0]),
      .pio_writedata(wd[0]), .owner(own[0]), .busy(busy[0]));

   led_pio_arbiter #(.NUM_REQ(N), .DATA_W(DW), .HOLD_CYCLES(0)) dut_h0 (
      .clk(clk), .reset_n(rst_n[1]), .req(req[1]), .req_data(req_data[1]), .ack(ack[1]),
      .pio_address(addr[1]), .pio_chipselect(cs[1]), .pio_write_n(wn[1]),
      .pio_writedata(wd[1]), .owner(own[1]), .busy(busy[1]));

   function automatic int hold_of(input int u);
      return (u == 0) ? 16 : 0;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic model_reset(input int u);
      e_ack[u]   = '0;
      e_cs[u]    = 1'b0;
      e_wn[u]    = 1'b1;
      e_wd[u]    = '0;
      e_own[u]   = N - 1;
      e_busy[u]  = 1'b0;
      blocked[u] = 0;
   endtask

   // blocked counts the cycles still spent writing/holding; a grant is possible only at 0
   task automatic model_step(input int u);
      int w;
      w = -1;
      if (blocked[u] == 0)
         for (int off = 1; off <= N; off++)
            if (w < 0 && req[u][(e_own[u] + off) % N]) w = (e_own[u] + off) % N;
      if (w >= 0) begin
         e_own[u]   = w;
         e_ack[u]   = N'(1 << w);
         e_cs[u]    = 1'b1;
         e_wn[u]    = 1'b0;
         e_wd[u]    = 32'(req_data[u][w*DW +: DW]);
         e_busy[u]  = 1'b1;
         blocked[u] = hold_of(u) + 1;
      end else begin
         e_ack[u] = '0;
         e_cs[u]  = 1'b0;
         e_wn[u]  = 1'b1;
         if (blocked[u] > 0) blocked[u] = blocked[u] - 1;
         e_busy[u] = (blocked[u] > 0);
      end
   endtask

   always @(posedge clk or negedge rst_n[0])
      if (!rst_n[0]) model_reset(0); else model_step(0);

   always @(posedge clk or negedge rst_n[1])
      if (!rst_n[1]) model_reset(1); else model_step(1);

   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (rst_n[u] === 1'b1) begin
            chk($sformatf("u%0d ack", u),       64'(ack[u]),  64'(e_ack[u]));
            chk($sformatf("u%0d chipsel", u),   64'(cs[u]),   64'(e_cs[u]));
            chk($sformatf("u%0d write_n", u),   64'(wn[u]),   64'(e_wn[u]));
            chk($sformatf("u%0d writedata", u), 64'(wd[u]),   64'(e_wd[u]));
            chk($sformatf("u%0d owner", u),     64'(own[u]),  64'(e_own[u]));
            chk($sformatf("u%0d busy", u),      64'(busy[u]), 64'(e_busy[u]));
            chk($sformatf("u%0d address", u),   64'(addr[u]), 64'd0);
         end
      end
   end

   task automatic wait_strobe(input int u, input int bound, input string nm, output int at);
      at = -1;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (cs[u] === 1'b1) begin
            at = cyc;
            break;
         end
      end
      chk({nm, " seen"}, 64'(at >= 0), 64'd1);
   endtask

   task automatic pulse_reset(input int u);
      @(negedge clk);
      rst_n[u] = 1'b0;
      @(negedge clk);
      rst_n[u] = 1'b1;
   endtask

   initial begin
      int at, prev, n;
      rst_n    = '0;
      req      = '0;
      req_data = '0;
      repeat (3) @(negedge clk);
      rst_n = 2'b11;
      @(negedge clk);
      chk("reset ack",       64'(ack[0]),  64'd0);
      chk("reset chipsel",   64'(cs[0]),   64'd0);
      chk("reset write_n",   64'(wn[0]),   64'd1);
      chk("reset writedata", 64'(wd[0]),   64'd0);
      chk("reset owner",     64'(own[0]),  64'd3);
      chk("reset busy",      64'(busy[0]), 64'd0);

      // single request, latency one cycle
      req_data[0][0 +: DW] = 8'hA5;
      req[0] = 4'b0001;
      prev = cyc;
      wait_strobe(0, 10, "t1 strobe", at);
      chk("t1 latency",   64'(at - prev), 64'd1);
      chk("t1 writedata", 64'(wd[0]),  64'h0000_00A5);
      chk("t1 ack",       64'(ack[0]), 64'b0001);
      chk("t1 owner",     64'(own[0]), 64'd0);
      req[0] = '0;

      // all requesting: order 0,1,2,3,0 and 18-cycle spacing
      pulse_reset(0);
      for (int i = 0; i < N; i++) req_data[0][i*DW +: DW] = 8'h10 + 8'(i);
      req[0] = '1;
      prev = 0;
      for (int k = 0; k < 5; k++) begin
         wait_strobe(0, 40, "t2 strobe", at);
         chk("t2 owner",     64'(own[0]), 64'(k % N));
         chk("t2 ack",       64'(ack[0]), 64'(1 << (k % N)));
         chk("t2 writedata", 64'(wd[0]),  64'(32'h10 + k % N));
         if (k > 0) chk("t2 spacing", 64'(at - prev), 64'd18);
         prev = at;
      end
      req[0] = '0;

      // wrap: owner=2 then 1001 grants 3, then 0
      pulse_reset(0);
      req[0] = 4'b0100;
      wait_strobe(0, 10, "t3 first", at);
      chk("t3 owner2", 64'(own[0]), 64'd2);
      req[0] = 4'b1001;
      wait_strobe(0, 40, "t3 wrap", at);
      chk("t3 owner3", 64'(own[0]), 64'd3);
      chk("t3 ack3",   64'(ack[0]), 64'b1000);
      wait_strobe(0, 40, "t3 next", at);
      chk("t3 owner0", 64'(own[0]), 64'd0);
      chk("t3 ack0",   64'(ack[0]), 64'b0001);
      req[0] = '0;

      // reset during the WRITE cycle
      req[0] = 4'b0001;
      wait_strobe(0, 40, "t5 strobe", at);
      #1 rst_n[0] = 1'b0;
      #1;
      chk("t5 chipsel", 64'(cs[0]),   64'd0);
      chk("t5 write_n", 64'(wn[0]),   64'd1);
      chk("t5 ack",     64'(ack[0]),  64'd0);
      chk("t5 owner",   64'(own[0]),  64'd3);
      chk("t5 busy",    64'(busy[0]), 64'd0);
      req[0] = 4'b0100;
      req_data[0][2*DW +: DW] = 8'h77;
      @(negedge clk);
      rst_n[0] = 1'b1;
      wait_strobe(0, 10, "t5 regrant", at);
      chk("t5 regrant owner", 64'(own[0]), 64'd2);
      chk("t5 regrant data",  64'(wd[0]),  64'h77);
      chk("t5 regrant ack",   64'(ack[0]), 64'b0100);
      req[0] = '0;

      // request raised and dropped during HOLD is lost
      @(negedge clk);
      req_data[0][2*DW +: DW] = 8'hEE;
      req[0] = 4'b0100;
      repeat (5) @(negedge clk);
      req[0] = '0;
      n = 0;
      repeat (30) begin
         @(negedge clk);
         if (cs[0] === 1'b1 || ack[0][2] === 1'b1) n++;
      end
      chk("t6 lost request", 64'(n), 64'd0);

      // HOLD_CYCLES=0: strobe every 2 cycles, stops once req drops
      req_data[1][1*DW +: DW] = 8'h5C;
      req[1] = 4'b0010;
      wait_strobe(1, 10, "t4 first", prev);
      for (int k = 0; k < 4; k++) begin
         wait_strobe(1, 10, "t4 strobe", at);
         chk("t4 spacing", 64'(at - prev), 64'd2);
         chk("t4 ack",     64'(ack[1]),    64'b0010);
         chk("t4 data",    64'(wd[1]),     64'h5C);
         prev = at;
      end
      req[1] = '0;
      n = 0;
      repeat (10) begin
         @(negedge clk);
         if (cs[1] === 1'b1) n++;
      end
      chk("t4 stop", 64'(n), 64'd0);

      // random requesters on both instances, model checks every cycle
      for (int t = 0; t < 1500; t++) begin
         @(negedge clk);
         for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < N; i++) begin
               if (req[u][i]) begin
                  if (ack[u][i]) begin
                     if ($urandom_range(3) != 0) req[u][i] = 1'b0;
                  end else if ($urandom_range(40) == 0) begin
                     req[u][i] = 1'b0;
                  end
                  if ($urandom_range(7) == 0) req_data[u][i*DW +: DW] = 8'($urandom);
               end else if ($urandom_range(5) == 0) begin
                  req[u][i] = 1'b1;
                  req_data[u][i*DW +: DW] = 8'($urandom);
               end
            end
         end
      end
      req = '0;
      repeat (20) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
